// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID pipeline register, 32x32 register file with
// write-through bypass, immediate generation and early branch/JAL resolution.
module id_stage #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_valid,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_wb_en,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data,
  output logic [4:0]  o_rd,
  output logic [31:0] o_imm_i,
  output logic [31:0] o_imm_b,
  output logic [31:0] o_imm_j,
  output logic        o_btaken,
  output logic        o_jal,
  output logic        o_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic        r_valid;
  logic [31:0] r_inst;
  logic [31:0] r_pc;
  logic [31:0] r_regs [32];

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic        w_wb_active;
  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;
  logic        w_cond;
  logic        w_bad_funct3;
  logic        w_known_op;

  // Register writes proceed regardless of stall/flush; only reset discards them.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_valid <= 1'b0;
      r_inst  <= NOP_INST;
      r_pc    <= 32'd0;
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else begin
      if (i_flush) begin
        r_valid <= 1'b0;
        r_inst  <= NOP_INST;
        r_pc    <= 32'd0;
      end else if (!i_stall) begin
        r_valid <= i_valid;
        r_inst  <= i_valid ? i_inst : NOP_INST;
        r_pc    <= i_pc;
      end
      if (w_wb_active) r_regs[i_wb_rd] <= i_wb_data;
    end
  end

  assign w_opcode    = r_inst[6:0];
  assign w_funct3    = r_inst[14:12];
  assign w_rs1       = r_inst[19:15];
  assign w_rs2       = r_inst[24:20];
  assign w_wb_active = i_wb_en && (i_wb_rd != 5'd0);

  // Same-cycle bypass so a writeback landing now is seen by this decode.
  always_comb begin
    w_rs1_data = r_regs[w_rs1];
    w_rs2_data = r_regs[w_rs2];
    if (w_rs1 == 5'd0) w_rs1_data = 32'd0;
    else if (w_wb_active && i_wb_rd == w_rs1) w_rs1_data = i_wb_data;
    if (w_rs2 == 5'd0) w_rs2_data = 32'd0;
    else if (w_wb_active && i_wb_rd == w_rs2) w_rs2_data = i_wb_data;
  end

  always_comb begin
    w_cond       = 1'b0;
    w_bad_funct3 = 1'b0;
    case (w_funct3)
      3'b000:  w_cond = (w_rs1_data == w_rs2_data);
      3'b001:  w_cond = (w_rs1_data != w_rs2_data);
      3'b100:  w_cond = ($signed(w_rs1_data) <  $signed(w_rs2_data));
      3'b101:  w_cond = ($signed(w_rs1_data) >= $signed(w_rs2_data));
      3'b110:  w_cond = (w_rs1_data <  w_rs2_data);
      3'b111:  w_cond = (w_rs1_data >= w_rs2_data);
      default: w_bad_funct3 = 1'b1;
    endcase
  end

  always_comb begin
    w_known_op = 1'b0;
    case (w_opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_REG: w_known_op = 1'b1;
      default:                           w_known_op = 1'b0;
    endcase
  end

  assign o_valid    = r_valid;
  assign o_pc       = r_pc;
  assign o_inst     = r_inst;
  assign o_rs1_data = w_rs1_data;
  assign o_rs2_data = w_rs2_data;
  assign o_rd       = r_inst[11:7];
  assign o_imm_i    = {{20{r_inst[31]}}, r_inst[31:20]};
  assign o_imm_b    = {{19{r_inst[31]}}, r_inst[31], r_inst[7], r_inst[30:25], r_inst[11:8], 1'b0};
  assign o_imm_j    = {{11{r_inst[31]}}, r_inst[31], r_inst[19:12], r_inst[20], r_inst[30:21], 1'b0};
  assign o_jal      = r_valid && (w_opcode == OP_JAL);
  assign o_btaken   = r_valid && (w_opcode == OP_BRANCH) && w_cond && !w_bad_funct3;
  assign o_illegal  = r_valid && (!w_known_op || ((w_opcode == OP_BRANCH) && w_bad_funct3));

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: scenario tasks with a scoreboard of
// expected IF/ID contents {valid, pc, inst} and a reference register file.
module tb_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int W = 65;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_inst = 32'd0;
  logic [31:0] i_pc = 32'd0;
  logic        i_stall = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_wb_en = 1'b0;
  logic [4:0]  i_wb_rd = 5'd0;
  logic [31:0] i_wb_data = 32'd0;
  logic        o_valid;
  logic [31:0] o_pc, o_inst, o_rs1_data, o_rs2_data;
  logic [4:0]  o_rd;
  logic [31:0] o_imm_i, o_imm_b, o_imm_j;
  logic        o_btaken, o_jal, o_illegal;

  id_stage #(.NOP_INST(NOP)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .i_inst(i_inst), .i_pc(i_pc),
    .i_stall(i_stall), .i_flush(i_flush), .i_wb_en(i_wb_en), .i_wb_rd(i_wb_rd),
    .i_wb_data(i_wb_data), .o_valid(o_valid), .o_pc(o_pc), .o_inst(o_inst),
    .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data), .o_rd(o_rd), .o_imm_i(o_imm_i),
    .o_imm_b(o_imm_b), .o_imm_j(o_imm_j), .o_btaken(o_btaken), .o_jal(o_jal),
    .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  logic         mdl_valid;
  logic [31:0]  mdl_inst, mdl_pc;
  logic [31:0]  mdl_regs [32];
  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Drive one cycle of fetch-side inputs and push the IF/ID contents expected after the edge.
  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic stall, input logic flush);
    i_valid = v; i_inst = inst; i_pc = pc; i_stall = stall; i_flush = flush;
    if (flush) begin
      mdl_valid = 1'b0; mdl_inst = NOP; mdl_pc = 32'd0;
    end else if (!stall) begin
      mdl_valid = v; mdl_inst = v ? inst : NOP; mdl_pc = pc;
    end
    exp_q.push_back({mdl_valid, mdl_pc, mdl_inst});
  endtask

  task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
    i_wb_en = en; i_wb_rd = rd; i_wb_data = data;
    if (en && rd != 5'd0) mdl_regs[rd] = data;
  endtask

  task automatic pop_check(input string name);
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, got %h", name, {o_valid, o_pc, o_inst});
    end else begin
      exp_v = exp_q.pop_front();
      if ({o_valid, o_pc, o_inst} !== exp_v) begin
        n_err++;
        $display("FAIL %s: ifid got %h expected %h", name, {o_valid, o_pc, o_inst}, exp_v);
      end
    end
  endtask

  task automatic test_reset();
    i_rstn = 1'b0;
    i_stall = 1'b1; i_flush = 1'b1; i_valid = 1'b1; i_inst = 32'hDEAD_BEEF;
    mdl_valid = 1'b0; mdl_inst = NOP; mdl_pc = 32'd0;
    for (int i = 0; i < 32; i++) mdl_regs[i] = 32'd0;
    exp_q.push_back({1'b0, 32'd0, NOP});
    tick();
    i_rstn = 1'b1; i_stall = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
    pop_check("reset_ifid");
    n_cmp++;
    if ({o_btaken, o_jal, o_illegal} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b expected 000", {o_btaken, o_jal, o_illegal});
    end
    n_cmp++;
    if ({o_rs1_data, o_rs2_data, o_imm_i, o_imm_b, o_imm_j} !== 160'd0) begin
      n_err++; $display("FAIL reset_data: rs1 %h rs2 %h immi %h immb %h immj %h expected all 0",
                        o_rs1_data, o_rs2_data, o_imm_i, o_imm_b, o_imm_j);
    end
  endtask

  task automatic test_addi();
    drive(1'b1, 32'h0050_0093, 32'd0, 1'b0, 1'b0);
    tick();
    pop_check("addi_ifid");
    n_cmp++;
    if ({o_valid, o_rd, o_imm_i, o_illegal} !== {1'b1, 5'd1, 32'd5, 1'b0}) begin
      n_err++; $display("FAIL addi_decode: valid %b rd %0d imm_i %h illegal %b expected 1 1 5 0",
                        o_valid, o_rd, o_imm_i, o_illegal);
    end
  endtask

  task automatic test_branch_bypass();
    drive(1'b1, 32'h0020_8463, 32'h100, 1'b0, 1'b0);
    tick();
    pop_check("beq_ifid");
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    wb(1'b1, 5'd1, 32'hFFFF_FFFF);
    #1;
    n_cmp++;
    if ({o_rs1_data, o_rs2_data, o_btaken} !== {32'hFFFF_FFFF, 32'd0, 1'b0}) begin
      n_err++; $display("FAIL beq_bypass: rs1 %h rs2 %h btaken %b expected ffffffff 0 0",
                        o_rs1_data, o_rs2_data, o_btaken);
    end
    tick();
    wb(1'b0, 5'd0, 32'd0);
    #1;
    pop_check("beq_stall_hold");
    n_cmp++;
    if (o_rs1_data !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL x1_stored: rs1 %h expected ffffffff", o_rs1_data);
    end
    drive(1'b1, 32'h0011_6463, 32'h104, 1'b0, 1'b0);
    tick();
    pop_check("bltu_ifid");
    n_cmp++;
    if ({o_btaken, o_imm_b} !== {1'b1, 32'd8}) begin
      n_err++; $display("FAIL bltu: btaken %b imm_b %h expected 1 8", o_btaken, o_imm_b);
    end
    drive(1'b1, 32'h0011_4463, 32'h108, 1'b0, 1'b0);
    tick();
    pop_check("blt_ifid");
    n_cmp++;
    if (o_btaken !== 1'b0) begin
      n_err++; $display("FAIL blt_signed: btaken %b expected 0", o_btaken);
    end
    drive(1'b1, 32'h0011_5463, 32'h10C, 1'b0, 1'b0);
    tick();
    pop_check("bge_ifid");
    n_cmp++;
    if (o_btaken !== 1'b1) begin
      n_err++; $display("FAIL bge_signed: btaken %b expected 1", o_btaken);
    end
  endtask

  task automatic test_jal();
    drive(1'b1, 32'h0080_006F, 32'h200, 1'b0, 1'b0);
    tick();
    pop_check("jal_ifid");
    n_cmp++;
    if ({o_jal, o_imm_j, o_btaken, o_illegal} !== {1'b1, 32'd8, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL jal_fwd: jal %b imm_j %h btaken %b illegal %b expected 1 8 0 0",
                        o_jal, o_imm_j, o_btaken, o_illegal);
    end
    drive(1'b1, 32'hFFDF_F06F, 32'h204, 1'b0, 1'b0);
    tick();
    pop_check("jal_back_ifid");
    n_cmp++;
    if ({o_jal, o_imm_j} !== {1'b1, 32'hFFFF_FFFC}) begin
      n_err++; $display("FAIL jal_back: jal %b imm_j %h expected 1 fffffffc", o_jal, o_imm_j);
    end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 32'h0030_0113, 32'h300, 1'b0, 1'b0);
    tick();
    pop_check("pre_stall_ifid");
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h0000_0033 + 32'(i << 7), 32'h304 + 32'(i * 4), 1'b1, 1'b0);
      tick();
      pop_check("stall_hold");
    end
    drive(1'b1, 32'h0040_0193, 32'h30C, 1'b1, 1'b1);
    tick();
    pop_check("stall_flush");
    n_cmp++;
    if ({o_valid, o_inst} !== {1'b0, 32'h0000_0013}) begin
      n_err++; $display("FAIL flush_bubble: valid %b inst %h expected 0 00000013", o_valid, o_inst);
    end
  endtask

  task automatic test_x0_illegal();
    drive(1'b1, 32'h0000_0033, 32'h400, 1'b0, 1'b0);
    tick();
    pop_check("add_x0_ifid");
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    wb(1'b1, 5'd0, 32'h0000_1234);
    #1;
    n_cmp++;
    if (o_rs1_data !== 32'd0) begin
      n_err++; $display("FAIL x0_no_bypass: rs1 %h expected 0", o_rs1_data);
    end
    tick();
    wb(1'b0, 5'd0, 32'd0);
    #1;
    pop_check("x0_stall_hold");
    n_cmp++;
    if ({o_rs1_data, o_rs2_data} !== 64'd0) begin
      n_err++; $display("FAIL x0_reads_zero: rs1 %h rs2 %h expected 0 0", o_rs1_data, o_rs2_data);
    end
    drive(1'b1, 32'h0000_007F, 32'h404, 1'b0, 1'b0);
    tick();
    pop_check("illegal_ifid");
    n_cmp++;
    if ({o_illegal, o_jal, o_btaken} !== 3'b100) begin
      n_err++; $display("FAIL illegal_op: illegal/jal/btaken %b expected 100", {o_illegal, o_jal, o_btaken});
    end
    drive(1'b1, 32'h0000_2063, 32'h408, 1'b0, 1'b0);
    tick();
    pop_check("bad_branch_ifid");
    n_cmp++;
    if ({o_illegal, o_btaken} !== 2'b10) begin
      n_err++; $display("FAIL bad_funct3: illegal/btaken %b expected 10", {o_illegal, o_btaken});
    end
    drive(1'b0, 32'h0000_007F, 32'h40C, 1'b0, 1'b0);
    tick();
    pop_check("invalid_ifid");
    n_cmp++;
    if ({o_valid, o_illegal} !== 2'b00) begin
      n_err++; $display("FAIL invalid_quiet: valid/illegal %b expected 00", {o_valid, o_illegal});
    end
  endtask

  task automatic test_reset_midstall();
    drive(1'b1, 32'h0002_8093, 32'h500, 1'b0, 1'b0);
    wb(1'b1, 5'd5, 32'd7);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    #1;
    pop_check("x5_ifid");
    n_cmp++;
    if (o_rs1_data !== 32'd7) begin
      n_err++; $display("FAIL x5_written: rs1 %h expected 7", o_rs1_data);
    end
    i_rstn = 1'b0;
    i_stall = 1'b1; i_valid = 1'b1; i_inst = 32'h0000_0033;
    i_wb_en = 1'b1; i_wb_rd = 5'd5; i_wb_data = 32'd9;
    mdl_valid = 1'b0; mdl_inst = NOP; mdl_pc = 32'd0;
    for (int i = 0; i < 32; i++) mdl_regs[i] = 32'd0;
    exp_q.push_back({1'b0, 32'd0, NOP});
    tick();
    i_rstn = 1'b1; i_stall = 1'b0; i_valid = 1'b0;
    wb(1'b0, 5'd0, 32'd0);
    #1;
    pop_check("midstall_reset_ifid");
    drive(1'b1, 32'h0002_8093, 32'h504, 1'b0, 1'b0);
    tick();
    pop_check("x5_reload_ifid");
    n_cmp++;
    if (o_rs1_data !== 32'd0) begin
      n_err++; $display("FAIL x5_cleared: rs1 %h expected 0", o_rs1_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] inst;
    logic [4:0]  rd;
    for (int i = 0; i < 32; i++) begin
      inst = $urandom;
      rd = 5'($urandom_range(0, 31));
      wb(($urandom_range(0, 3) != 0), rd, $urandom);
      drive(($urandom_range(0, 3) != 0), inst, $urandom, ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 7) == 0));
      tick();
      wb(1'b0, 5'd0, 32'd0);
      #1;
      pop_check("b2b_ifid");
      n_cmp++;
      if ({o_rd, o_imm_i} !== {mdl_inst[11:7], {{20{mdl_inst[31]}}, mdl_inst[31:20]}}) begin
        n_err++; $display("FAIL b2b_decode: rd %0d imm_i %h expected %0d %h", o_rd, o_imm_i,
                          mdl_inst[11:7], {{20{mdl_inst[31]}}, mdl_inst[31:20]});
      end
      n_cmp++;
      if ({o_rs1_data, o_rs2_data} !== {mdl_regs[mdl_inst[19:15]], mdl_regs[mdl_inst[24:20]]}) begin
        n_err++; $display("FAIL b2b_regfile: rs1 %h rs2 %h expected %h %h", o_rs1_data, o_rs2_data,
                          mdl_regs[mdl_inst[19:15]], mdl_regs[mdl_inst[24:20]]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl_regs[i] = 32'd0;
    mdl_valid = 1'b0; mdl_inst = NOP; mdl_pc = 32'd0;
    tick();
    test_reset();
    test_addi();
    test_branch_bypass();
    test_jal();
    test_stall_flush();
    test_x0_illegal();
    test_reset_midstall();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
